// File: rtl/transmit_shift_stream_if.sv
// rtl/transmit_shift_stream_if.sv - word stream handshake into the transmit shifter
interface transmit_shift_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/transmit_shift_stream.sv
// rtl/transmit_shift_stream.sv - word-stream to serial shifter with holding register, bit period, eop/underrun
module transmit_shift_stream #(
  parameter int   DATA_WIDTH = 8,
  parameter int   BIT_PERIOD = 1,
  parameter int   LSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  transmit_shift_stream_if.slave  in_if,
  input  logic                    abort,
  output logic                    serial_out,
  output logic                    bit_strobe,
  output logic                    tx_active,
  output logic                    eop,
  output logic                    underrun
);
  localparam int DIV_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_last_q, hold_last_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  last_flag_q, last_flag_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  eop_q, eop_d;
  logic                  underrun_q, underrun_d;

  logic accept, strobe, word_end, load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      last_flag_q <= 1'b0;
      div_q       <= '0;
      bitcnt_q    <= '0;
      eop_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      last_flag_q <= last_flag_d;
      div_q       <= div_d;
      bitcnt_q    <= bitcnt_d;
      eop_q       <= eop_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    last_flag_d = last_flag_q;
    div_d       = div_q;
    bitcnt_d    = bitcnt_q;
    eop_d       = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    accept   = in_if.in_valid && !hold_full_q;
    strobe   = (state_q == SHIFT) && (div_q == DIV_LAST);
    word_end = strobe && (bitcnt_q == CNT_LAST);

    // accept and load are mutually exclusive: accept needs hold empty, load needs it full
    if (accept) begin
      hold_d      = in_if.in_data;
      hold_last_d = in_if.in_last;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: load = hold_full_q;
      SHIFT: begin
        if (strobe) begin
          div_d    = '0;
          bitcnt_d = bitcnt_q + 1'b1;
          shreg_d  = (LSB_FIRST != 0) ? {1'b0, shreg_q[DATA_WIDTH-1:1]}
                                      : {shreg_q[DATA_WIDTH-2:0], 1'b0};
          if (word_end) begin
            bitcnt_d = '0;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d    = IDLE;
              eop_d      = last_flag_q;
              underrun_d = !last_flag_q;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = SHIFT;
      shreg_d     = hold_q;
      last_flag_d = hold_last_q;
      hold_full_d = 1'b0;
      div_d       = '0;
      bitcnt_d    = '0;
    end

    if (abort) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      div_d       = '0;
      bitcnt_d    = '0;
      eop_d       = 1'b0;
      underrun_d  = 1'b0;
    end
  end

  assign in_if.in_ready = !hold_full_q;
  assign tx_active      = (state_q == SHIFT);
  assign bit_strobe     = (state_q == SHIFT) && (div_q == DIV_LAST);
  assign serial_out     = (state_q != SHIFT) ? IDLE_LEVEL
                        : (LSB_FIRST != 0)   ? shreg_q[0] : shreg_q[DATA_WIDTH-1];
  assign eop            = eop_q;
  assign underrun       = underrun_q;
endmodule

// File: tb/tb_transmit_shift_stream.sv
// tb/tb_transmit_shift_stream.sv - scoreboard bench for the transmit shifter (two parameter sets)
module tb_transmit_shift_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, abort_a, abort_b;
  logic so_a, bs_a, ta_a, eop_a, ur_a;
  logic so_b, bs_b, ta_b, eop_b, ur_b;

  transmit_shift_stream_if #(.DATA_WIDTH(8)) if_a ();
  transmit_shift_stream_if #(.DATA_WIDTH(8)) if_b ();

  transmit_shift_stream #(.DATA_WIDTH(8), .BIT_PERIOD(1), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) u_dut_a (
    .clk(clk), .rst(rst_a), .in_if(if_a.slave), .abort(abort_a),
    .serial_out(so_a), .bit_strobe(bs_a), .tx_active(ta_a), .eop(eop_a), .underrun(ur_a)
  );

  transmit_shift_stream #(.DATA_WIDTH(8), .BIT_PERIOD(4), .LSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_if(if_b.slave), .abort(abort_b),
    .serial_out(so_b), .bit_strobe(bs_b), .tx_active(ta_b), .eop(eop_b), .underrun(ur_b)
  );

  // expected event codes: 0/1 = bit value at its strobe, 2 = eop, 3 = underrun
  int checks = 0;
  int failures = 0;
  int exp_a[$];
  int exp_b[$];
  int ea, eb;
  int run_a = 0;
  int last_run_a = 0;
  int div_cnt_b = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int which, input logic [7:0] seq, input int n, input int evt);
    for (int i = 0; i < n; i++) begin
      if (which == 0) exp_a.push_back(int'(seq[7-i]));
      else            exp_b.push_back(int'(seq[7-i]));
    end
    if (evt >= 0) begin
      if (which == 0) exp_a.push_back(evt);
      else            exp_b.push_back(evt);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int which, input logic [7:0] d, input logic l);
    int n = 0;
    if (which == 0) begin
      if_a.in_valid = 1'b1; if_a.in_data = d; if_a.in_last = l;
      while (!if_a.in_ready && n < 400) begin @(negedge clk); n++; end
    end else begin
      if_b.in_valid = 1'b1; if_b.in_data = d; if_b.in_last = l;
      while (!if_b.in_ready && n < 400) begin @(negedge clk); n++; end
    end
    if (n >= 400) chk("send_timeout", n, 0);
    @(negedge clk);
    if (which == 0) if_a.in_valid = 1'b0;
    else            if_b.in_valid = 1'b0;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 400) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk((which == 0) ? "drain_a" : "drain_b", (which == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_a) begin
      if (bs_a) begin
        ea = (exp_a.size() != 0) ? exp_a.pop_front() : -1;
        chk("a_bit", so_a, ea);
      end
      if (eop_a) begin
        ea = (exp_a.size() != 0) ? exp_a.pop_front() : -1;
        chk("a_eop_event", ea, 2);
        chk("a_eop_idle_level", so_a, 1);
        chk("a_eop_tx_active", ta_a, 0);
      end
      if (ur_a) begin
        ea = (exp_a.size() != 0) ? exp_a.pop_front() : -1;
        chk("a_underrun_event", ea, 3);
        chk("a_underrun_idle_level", so_a, 1);
      end
      if (ta_a) run_a++;
      else begin
        if (run_a > 0) last_run_a = run_a;
        run_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) div_cnt_b = 0;
    else begin
      if (bs_b) begin
        eb = (exp_b.size() != 0) ? exp_b.pop_front() : -1;
        chk("b_bit", so_b, eb);
        chk("b_bit_period", div_cnt_b, 3);
      end
      if (eop_b) begin
        eb = (exp_b.size() != 0) ? exp_b.pop_front() : -1;
        chk("b_eop_event", eb, 2);
        chk("b_eop_idle_level", so_b, 1);
      end
      if (ur_b) begin
        eb = (exp_b.size() != 0) ? exp_b.pop_front() : -1;
        chk("b_underrun_event", eb, 3);
      end
      if (ta_b && !bs_b) div_cnt_b++;
      else div_cnt_b = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; abort_a = 1'b0; abort_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_data = 8'h00; if_a.in_last = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = 8'h00; if_b.in_last = 1'b0;
    #2;
    chk("rst_a_in_ready", if_a.in_ready, 1);
    chk("rst_a_serial_out", so_a, 1);
    chk("rst_a_bit_strobe", bs_a, 0);
    chk("rst_a_tx_active", ta_a, 0);
    chk("rst_a_eop", eop_a, 0);
    chk("rst_a_underrun", ur_a, 0);
    chk("rst_b_in_ready", if_b.in_ready, 1);
    chk("rst_b_serial_out", so_b, 1);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // 0xA5 last, LSB first: 1,0,1,0,0,1,0,1 then eop
    push_exp(0, 8'b10100101, 8, 2);
    send(0, 8'hA5, 1'b1);
    chk("lat_cycle0_tx_active", ta_a, 0);
    chk("lat_cycle0_in_ready", if_a.in_ready, 0);
    @(negedge clk);
    chk("lat_cycle1_tx_active", ta_a, 1);
    chk("lat_cycle1_bit0", so_a, 1);
    drain(0);
    chk("single_word_active_cycles", last_run_a, 8);

    // back-to-back 0xFF, 0x00 last: 16 gapless bits, one eop
    push_exp(0, 8'b11111111, 8, -1);
    push_exp(0, 8'b00000000, 8, 2);
    send(0, 8'hFF, 1'b0);
    send(0, 8'h00, 1'b1);
    chk("b2b_hold_full_ready", if_a.in_ready, 0);
    drain(0);
    chk("b2b_active_cycles", last_run_a, 16);

    // late source: 0x0F not last -> underrun, then 0x33 last
    push_exp(0, 8'b11110000, 8, 3);
    send(0, 8'h0F, 1'b0);
    drain(0);
    chk("underrun_idle_level", so_a, 1);
    chk("underrun_tx_active", ta_a, 0);
    chk("underrun_active_cycles", last_run_a, 8);
    push_exp(0, 8'b11001100, 8, 2);
    send(0, 8'h33, 1'b1);
    drain(0);

    // abort during bit 3 of 0x3C with 0x96 held: bits 0..3 only, nothing after
    push_exp(0, 8'b00111100, 4, -1);
    send(0, 8'h3C, 1'b0);
    send(0, 8'h96, 1'b1);
    repeat (2) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_tx_active", ta_a, 0);
    chk("abort_in_ready", if_a.in_ready, 1);
    chk("abort_serial_out", so_a, 1);
    chk("abort_eop", eop_a, 0);
    chk("abort_underrun", ur_a, 0);
    repeat (12) @(negedge clk);
    drain(0);

    // MSB first, 4-cycle bits: 0x81 -> 1,0,0,0,0,0,0,1 then eop
    push_exp(1, 8'b10000001, 8, 2);
    send(1, 8'h81, 1'b1);
    drain(1);

    // async reset in the middle of bit 1 of 0xC3, then a clean 0x5A
    push_exp(1, 8'b11000011, 1, -1);
    send(1, 8'hC3, 1'b1);
    repeat (6) @(negedge clk);
    #2 rst_b = 1'b1;
    #1;
    chk("arst_tx_active", ta_b, 0);
    chk("arst_serial_out", so_b, 1);
    chk("arst_bit_strobe", bs_b, 0);
    chk("arst_in_ready", if_b.in_ready, 1);
    chk("arst_eop", eop_b, 0);
    chk("arst_underrun", ur_b, 0);
    chk("arst_bit0_seen", exp_b.size(), 0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    push_exp(1, 8'b01011010, 8, 2);
    send(1, 8'h5A, 1'b1);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
